// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the five-stage LoongArch pipeline.
// Commits the instruction held from the memory stage (register file, CSR and
// TLB-op strobes), raises exception / ertn / refetch flush pulses and drives the
// retire trace. Optional feature macro: WB_TRACE_EN enables the debug_wb_* trace
// ports and a simulation-visible retire counter; otherwise they are tied to 0.
module wb_stage (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_wb_valid,
    input  logic [242:0]  mem_wb_bus,
    output logic          wb_allowin,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [37:0]   wb_id_bus,
    output logic          csr_re,
    output logic [13:0]   csr_num,
    input  logic [31:0]   csr_rvalue,
    output logic          csr_we,
    output logic [31:0]   csr_wmask,
    output logic [31:0]   csr_wvalue,
    output logic          wb_ex,
    output logic          ertn_flush,
    output logic          tlb_reflush,
    output logic [5:0]    wb_ecode,
    output logic [8:0]    wb_esubcode,
    output logic [31:0]   wb_pc,
    output logic [31:0]   wb_vaddr,
    output logic          tlb_srch_we,
    output logic          tlb_rd,
    output logic          tlb_wr,
    output logic          tlb_fill,
    output logic          tlb_inv,
    output logic          tlb_s1_found,
    output logic [3:0]    tlb_s1_index,
    output logic [31:0]   refetch_pc,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_we,
    output logic [4:0]    debug_wb_rf_wnum,
    output logic [31:0]   debug_wb_rf_wdata
);

    logic         wb_valid;
    logic         flush_hold;
    logic [242:0] bus_r;
    logic         wb_ready_go;
    logic         c;
    logic         flush;

    // Fields of the latched memory-stage bus, MSB first
    logic        gr_we_f;
    logic [31:0] pc_f;
    logic [31:0] result_f;
    logic [4:0]  dest_f;
    logic        csr_we_f;
    logic        csr_re_f;
    logic [13:0] csr_num_f;
    logic [31:0] csr_wmask_f;
    logic [31:0] csr_wvalue_f;
    logic        ertn_f;
    logic [31:0] vaddr_f;
    logic        ex_f;
    logic [8:0]  esubcode_f;
    logic [5:0]  ecode_f;
    logic        tlbsrch_f;
    logic        tlbrd_f;
    logic        tlbwr_f;
    logic        tlbfill_f;
    logic        invtlb_f;
    logic        s1_found_f;
    logic [3:0]  s1_index_f;
    logic        zombie_f;
    logic        unused_bits;

    assign gr_we_f      = bus_r[242];
    assign pc_f         = bus_r[241:210];
    assign result_f     = bus_r[177:146];
    assign dest_f       = bus_r[145:141];
    assign csr_we_f     = bus_r[140];
    assign csr_re_f     = bus_r[139];
    assign csr_num_f    = bus_r[138:125];
    assign csr_wmask_f  = bus_r[124:93];
    assign csr_wvalue_f = bus_r[92:61];
    assign ertn_f       = bus_r[60];
    assign vaddr_f      = bus_r[58:27];
    assign ex_f         = bus_r[26];
    assign esubcode_f   = bus_r[25:17];
    assign ecode_f      = bus_r[16:11];
    assign tlbsrch_f    = bus_r[10];
    assign tlbrd_f      = bus_r[9];
    assign tlbwr_f      = bus_r[8];
    assign tlbfill_f    = bus_r[7];
    assign invtlb_f     = bus_r[6];
    assign s1_found_f   = bus_r[5];
    assign s1_index_f   = bus_r[4:1];
    assign zombie_f     = bus_r[0];
    // inst and syscall travel on the bus but are not needed at commit
    assign unused_bits  = ^{bus_r[209:178], bus_r[59]};

    assign wb_ready_go = 1'b1;
    assign wb_allowin  = ~wb_valid | wb_ready_go;

    // Commit qualifier: a live instruction that did not fault
    assign c = wb_valid & ~ex_f;

    // Flush pulses, mutually exclusive by construction: ex > ertn > refetch
    logic tlb_op;
    logic crit_csr;
    assign tlb_op      = ~zombie_f & (tlbwr_f | tlbfill_f | invtlb_f);
    assign crit_csr    = csr_we_f & ((csr_num_f == 14'h0) | (csr_num_f == 14'h18));
    assign wb_ex       = wb_valid & ex_f;
    assign ertn_flush  = c & ertn_f;
    assign tlb_reflush = c & ~ertn_f & (tlb_op | crit_csr);
    assign flush       = wb_ex | ertn_flush | tlb_reflush;

    // Stage occupancy; a flush drops the instruction arriving with it and the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            flush_hold <= 1'b0;
        end else begin
            flush_hold <= flush;
            if (flush)
                wb_valid <= 1'b0;
            else
                wb_valid <= mem_wb_valid & ~flush_hold;
        end
    end

    // Payload register, deliberately not reset; every use is gated by wb_valid
    always_ff @(posedge clk) begin
        if (mem_wb_valid & wb_allowin)
            bus_r <= mem_wb_bus;
    end

    // Register-file write and CSR read
    assign csr_re    = c & csr_re_f;
    assign csr_num   = wb_valid ? csr_num_f : 14'h0;
    assign rf_we     = c & gr_we_f & (dest_f != 5'd0);
    assign rf_waddr  = wb_valid ? dest_f : 5'd0;
    assign rf_wdata  = csr_re ? csr_rvalue : (wb_valid ? result_f : 32'h0);
    assign wb_id_bus = {wb_valid & gr_we_f, rf_waddr, rf_wdata};

    // CSR write
    assign csr_we     = c & csr_we_f;
    assign csr_wmask  = wb_valid ? csr_wmask_f  : 32'h0;
    assign csr_wvalue = wb_valid ? csr_wvalue_f : 32'h0;

    // Exception information for the CSR file
    assign wb_ecode    = wb_valid ? ecode_f    : 6'h0;
    assign wb_esubcode = wb_valid ? esubcode_f : 9'h0;
    assign wb_pc       = wb_valid ? pc_f       : 32'h0;
    assign wb_vaddr    = wb_valid ? vaddr_f    : 32'h0;

    // TLB strobes; a zombie TLB op retires as a nop
    assign tlb_srch_we  = c & ~zombie_f & tlbsrch_f;
    assign tlb_rd       = c & ~zombie_f & tlbrd_f;
    assign tlb_wr       = c & ~zombie_f & tlbwr_f;
    assign tlb_fill     = c & ~zombie_f & tlbfill_f;
    assign tlb_inv      = c & ~zombie_f & invtlb_f;
    assign tlb_s1_found = wb_valid & s1_found_f;
    assign tlb_s1_index = wb_valid ? s1_index_f : 4'h0;

    // Refetch address, wraps at 2^32
    assign refetch_pc = (wb_valid ? pc_f : 32'h0) + 32'd4;

`ifdef WB_TRACE_EN
    logic [31:0] retire_cnt;

    // Retire counter for simulation visibility
    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= 32'h0;
        else if (c)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    assign debug_wb_pc       = 32'h0;
    assign debug_wb_rf_we    = 4'h0;
    assign debug_wb_rf_wnum  = 5'h0;
    assign debug_wb_rf_wdata = 32'h0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed instruction vectors, a bench-side model of
// which instruction is in write-back and what it must produce, and literal
// checks on the specification's worked examples.
module tb_wb_stage;

    typedef struct {
        logic        gr_we;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        syscall;
        logic [31:0] vaddr;
        logic        ex;
        logic [8:0]  esub;
        logic [5:0]  ecode;
        logic        srch, rd, wr, fill, inv, found;
        logic [3:0]  idx;
        logic        zombie;
    } ins_t;

    typedef struct {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [37:0] id_bus;
        logic        csr_re;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] wmask, wvalue;
        logic        ex, ertn, refl;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] pc, vaddr;
        logic        srch, rd, wr, fill, inv, found;
        logic [3:0]  idx;
        logic [31:0] refetch;
    } out_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_wb_valid;
    logic [242:0] mem_wb_bus;
    logic         wb_allowin;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [37:0]  wb_id_bus;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_rvalue;
    logic         csr_we;
    logic [31:0]  csr_wmask, csr_wvalue;
    logic         wb_ex, ertn_flush, tlb_reflush;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [31:0]  wb_pc, wb_vaddr;
    logic         tlb_srch_we, tlb_rd, tlb_wr, tlb_fill, tlb_inv, tlb_s1_found;
    logic [3:0]   tlb_s1_index;
    logic [31:0]  refetch_pc;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    ins_t cur_ins;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .mem_wb_valid(mem_wb_valid), .mem_wb_bus(mem_wb_bus),
        .wb_allowin(wb_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_id_bus(wb_id_bus), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .tlb_reflush(tlb_reflush),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .tlb_srch_we(tlb_srch_we), .tlb_rd(tlb_rd), .tlb_wr(tlb_wr), .tlb_fill(tlb_fill),
        .tlb_inv(tlb_inv), .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
        .refetch_pc(refetch_pc), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t blank();
        ins_t i;
        i.gr_we = 0; i.pc = 0; i.inst = 0; i.result = 0; i.dest = 0;
        i.csr_we = 0; i.csr_re = 0; i.csr_num = 0; i.wmask = 0; i.wvalue = 0;
        i.ertn = 0; i.syscall = 0; i.vaddr = 0; i.ex = 0; i.esub = 0; i.ecode = 0;
        i.srch = 0; i.rd = 0; i.wr = 0; i.fill = 0; i.inv = 0; i.found = 0;
        i.idx = 0; i.zombie = 0;
        return i;
    endfunction

    function automatic logic [242:0] pack(input ins_t i);
        return {i.gr_we, i.pc, i.inst, i.result, i.dest,
                i.csr_we, i.csr_re, i.csr_num, i.wmask, i.wvalue,
                i.ertn, i.syscall, i.vaddr, i.ex, i.esub, i.ecode,
                i.srch, i.rd, i.wr, i.fill, i.inv, i.found, i.idx, i.zombie};
    endfunction

    // What write-back must present for instruction i (present when v)
    function automatic out_t model_out(input bit v, input ins_t i, input logic [31:0] rv);
        out_t o;
        bit commit, tlbop, tlbkind;
        commit = v && !i.ex;
        tlbkind = (i.wr || i.fill || i.inv) && !i.zombie;
        o.ex      = v && i.ex;
        o.ertn    = commit && i.ertn;
        o.refl    = commit && !i.ertn &&
                    (tlbkind || (i.csr_we && (i.csr_num == 14'h0 || i.csr_num == 14'h18)));
        o.rf_we   = commit && i.gr_we && (i.dest != 0);
        o.csr_re  = commit && i.csr_re;
        o.csr_we  = commit && i.csr_we;
        tlbop     = commit && !i.zombie;
        o.srch    = tlbop && i.srch;
        o.rd      = tlbop && i.rd;
        o.wr      = tlbop && i.wr;
        o.fill    = tlbop && i.fill;
        o.inv     = tlbop && i.inv;
        if (v) begin
            o.waddr = i.dest; o.csr_num = i.csr_num; o.wmask = i.wmask; o.wvalue = i.wvalue;
            o.ecode = i.ecode; o.esub = i.esub; o.pc = i.pc; o.vaddr = i.vaddr;
            o.found = i.found; o.idx = i.idx;
            o.wdata = o.csr_re ? rv : i.result;
            o.refetch = i.pc + 32'd4;
        end else begin
            o.waddr = 0; o.csr_num = 0; o.wmask = 0; o.wvalue = 0;
            o.ecode = 0; o.esub = 0; o.pc = 0; o.vaddr = 0;
            o.found = 0; o.idx = 0; o.wdata = 0; o.refetch = 32'd4;
        end
        o.id_bus = {v && i.gr_we, o.waddr, o.wdata};
        return o;
    endfunction

    // Model state: which instruction sits in write-back, and whether a flush just happened
    bit   m_v    = 0;
    bit   m_hold = 0;
    ins_t m_i;

    always @(posedge clk) begin
        out_t o;
        bit   f;
        o = model_out(m_v, m_i, csr_rvalue);
        f = o.ex || o.ertn || o.refl;
        m_v    = !reset && mem_wb_valid && !f && !m_hold;
        m_hold = !reset && f;
        if (mem_wb_valid) m_i = cur_ins;
        #3;
        o = model_out(m_v, m_i, csr_rvalue);
        chk("allowin", wb_allowin, 1);
        chk("rf_we", rf_we, o.rf_we);
        chk("rf_waddr", rf_waddr, o.waddr);
        chk("rf_wdata", rf_wdata, o.wdata);
        chk("wb_id_bus", wb_id_bus, o.id_bus);
        chk("csr_re", csr_re, o.csr_re);
        chk("csr_num", csr_num, o.csr_num);
        chk("csr_we", csr_we, o.csr_we);
        chk("csr_wmask", csr_wmask, o.wmask);
        chk("csr_wvalue", csr_wvalue, o.wvalue);
        chk("wb_ex", wb_ex, o.ex);
        chk("ertn_flush", ertn_flush, o.ertn);
        chk("tlb_reflush", tlb_reflush, o.refl);
        chk("wb_ecode", wb_ecode, o.ecode);
        chk("wb_esubcode", wb_esubcode, o.esub);
        chk("wb_pc", wb_pc, o.pc);
        chk("wb_vaddr", wb_vaddr, o.vaddr);
        chk("tlb_strobes", {tlb_srch_we, tlb_rd, tlb_wr, tlb_fill, tlb_inv},
            {o.srch, o.rd, o.wr, o.fill, o.inv});
        chk("tlb_s1", {tlb_s1_found, tlb_s1_index}, {o.found, o.idx});
        chk("refetch_pc", refetch_pc, o.refetch);
`ifdef WB_TRACE_EN
        chk("dbg_pc", debug_wb_pc, o.pc);
        chk("dbg_we", debug_wb_rf_we, {4{o.rf_we}});
        chk("dbg_wnum", debug_wb_rf_wnum, o.waddr);
        chk("dbg_wdata", debug_wb_rf_wdata, o.wdata);
`else
        chk("dbg_tied", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
`endif
    end

    // Offer instruction i (valid v) for one cycle; returns 2 time units after the edge
    task automatic send(input ins_t i, input bit v);
        cur_ins      = i;
        mem_wb_bus   = pack(i);
        mem_wb_valid = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t i;
        ins_t ld;
        reset        = 1'b1;
        mem_wb_valid = 1'b0;
        cur_ins      = blank();
        mem_wb_bus   = pack(cur_ins);
        csr_rvalue   = 32'hdeadbeef;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_allowin", wb_allowin, 1);
        chk("rst_refetch", refetch_pc, 32'd4);
        chk("rst_flush", {wb_ex, ertn_flush, tlb_reflush}, 0);
        chk("rst_dbg_we", debug_wb_rf_we, 0);
        reset = 1'b0;

        // ld result commit
        ld = blank(); ld.gr_we = 1; ld.dest = 5; ld.result = 32'h1234; ld.pc = 32'h1c000000;
        send(ld, 1);
        chk("ld_we", rf_we, 1);
        chk("ld_waddr", rf_waddr, 5);
        chk("ld_wdata", rf_wdata, 32'h1234);
`ifdef WB_TRACE_EN
        chk("ld_trace_pc", debug_wb_pc, 32'h1c000000);
        chk("ld_trace_we", debug_wb_rf_we, 4'hf);
`endif

        // CSR read
        i = blank(); i.gr_we = 1; i.dest = 6; i.csr_re = 1; i.csr_num = 14'h5; i.pc = 32'h1c000004;
        send(i, 1);
        chk("csrrd_wdata", rf_wdata, 32'hdeadbeef);
        chk("csrrd_re", csr_re, 1);

        // Exception, then two wrong-path arrivals dropped, then normal commit
        i = blank(); i.ex = 1; i.ecode = 6'hb; i.gr_we = 1; i.dest = 7; i.csr_we = 1;
        i.pc = 32'h1c000020; i.vaddr = 32'h55;
        send(i, 1);
        chk("ex_pulse", wb_ex, 1);
        chk("ex_rf_we", rf_we, 0);
        chk("ex_csr_we", csr_we, 0);
        chk("ex_ecode", wb_ecode, 6'hb);
        chk("ex_pc", wb_pc, 32'h1c000020);
        send(ld, 1);
        chk("ex_once", wb_ex, 0);
        chk("ex_drop1", rf_we, 0);
        send(ld, 1);
        chk("ex_drop2", rf_we, 0);
        send(ld, 1);
        chk("ex_resume", rf_we, 1);

        // ertn pulse
        i = blank(); i.ertn = 1; i.pc = 32'h1c000030;
        send(i, 1);
        chk("ertn_pulse", ertn_flush, 1);
        send(blank(), 0);
        chk("ertn_once", ertn_flush, 0);
        send(blank(), 0);

        // tlbwr refetch
        i = blank(); i.wr = 1; i.pc = 32'h1c000010;
        send(i, 1);
        chk("tlbwr_wr", tlb_wr, 1);
        chk("tlbwr_refl", tlb_reflush, 1);
        chk("tlbwr_refetch", refetch_pc, 32'h1c000014);
        send(blank(), 0);
        send(blank(), 0);

        // Zombie tlbfill retires as nop
        i = blank(); i.fill = 1; i.zombie = 1; i.pc = 32'h1c000040;
        send(i, 1);
        chk("zombie_fill", tlb_fill, 0);
        chk("zombie_refl", tlb_reflush, 0);

        // invtlb at top of address space: refetch_pc wraps
        i = blank(); i.inv = 1; i.pc = 32'hfffffffc;
        send(i, 1);
        chk("inv_strobe", tlb_inv, 1);
        chk("inv_wrap", refetch_pc, 32'h0);
        send(blank(), 0);
        send(blank(), 0);

        // CSR write to ASID forces refetch
        i = blank(); i.csr_we = 1; i.csr_num = 14'h18; i.wmask = 32'h3ff; i.wvalue = 32'h7;
        i.pc = 32'h1c000050;
        send(i, 1);
        chk("asid_we", csr_we, 1);
        chk("asid_refl", tlb_reflush, 1);
        send(blank(), 0);
        send(blank(), 0);

        // tlbsrch result
        i = blank(); i.srch = 1; i.found = 1; i.idx = 4'h9; i.pc = 32'h1c000060;
        send(i, 1);
        chk("srch_we", tlb_srch_we, 1);
        chk("srch_idx", tlb_s1_index, 4'h9);

        // r0 is never written
        i = blank(); i.gr_we = 1; i.dest = 0; i.result = 32'h77;
        send(i, 1);
        chk("r0_we", rf_we, 0);

        // Streaming, reset asserted with the 4th instruction
        for (int k = 0; k < 8; k++) begin
            i = blank(); i.gr_we = 1; i.dest = 5'(k + 1); i.result = 32'h100 + 32'(k);
            i.pc = 32'h1c001000 + 32'(4 * k);
            reset = (k == 3);
            send(i, 1);
            chk("stream_allowin", wb_allowin, 1);
            if (k == 3) begin
                chk("stream_rst_we", rf_we, 0);
            end else begin
                chk("stream_we", rf_we, 1);
                chk("stream_wdata", rf_wdata, 32'h100 + 32'(k));
            end
        end
        reset = 1'b0;
        send(blank(), 0);
        send(blank(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
